// File: rtl/dff_pipe.sv
// WIDTH-bit, DEPTH-stage delay line with stall, per-stage valid, flush,
// a runtime-selectable output tap and a registered occupancy count.
module dff_pipe #(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
    parameter int               SEL_W     = $clog2(DEPTH + 1)
) (
    input  logic             clk_in,
    input  logic             resetn_in,
    input  logic [WIDTH-1:0] d_in,
    input  logic             valid_in,
    input  logic             en_in,
    input  logic             flush_in,
    input  logic [SEL_W-1:0] sel_in,
    output logic [WIDTH-1:0] q_out,
    output logic             valid_out,
    output logic [SEL_W-1:0] count_out
);

    localparam logic [SEL_W-1:0] DEPTH_SEL = SEL_W'(DEPTH);

    // Index 0 is stage 1 (newest sample).
    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_next;
    logic [SEL_W-1:0] count_q;
    logic [SEL_W-1:0] count_next;
    logic [SEL_W-1:0] tap;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        valid_next = valid_q;
        if (en_in) begin
            valid_next[0] = valid_in;
            for (int k = 1; k < DEPTH; k++) begin
                valid_next[k] = valid_q[k-1];
            end
        end
        if (flush_in) begin
            valid_next = '0;
        end

        count_next = '0;
        for (int k = 0; k < DEPTH; k++) begin
            count_next = count_next + SEL_W'(valid_next[k]);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
    always_ff @(posedge clk_in) begin
        if (!resetn_in) begin
            // NOTE: data stages are reset too, since RESET_VAL must be visible on every tap.
            for (int k = 0; k < DEPTH; k++) begin
                stage_q[k] <= RESET_VAL;
            end
            valid_q <= '0;
            count_q <= '0;
        end else begin
            if (en_in) begin
                stage_q[0] <= d_in;
                for (int k = 1; k < DEPTH; k++) begin
                    stage_q[k] <= stage_q[k-1];
                end
            end
            valid_q <= valid_next;
            count_q <= count_next;
        end
    end

    // Tap clamps to 1..DEPTH; the mux reads registered state only.
    always_comb begin
        if (sel_in == '0) begin
            tap = SEL_W'(1);
        end else if (sel_in > DEPTH_SEL) begin
            tap = DEPTH_SEL;
        end else begin
            tap = sel_in;
        end

        q_out     = stage_q[0];
        valid_out = valid_q[0];
        for (int k = 0; k < DEPTH; k++) begin
            if (tap == SEL_W'(k + 1)) begin
                q_out     = stage_q[k];
                valid_out = valid_q[k];
            end
        end
    end

    assign count_out = count_q;

endmodule

// File: tb/tb_dff_pipe.sv
// Directed bench for dff_pipe: two instances (RESET_VAL 8'h00 and 8'h5A)
// share one stimulus stream; expected values are hand-computed constants.
module tb_dff_pipe;

    logic       clk_in = 1'b0;
    logic       resetn_in;
    logic [7:0] d_in;
    logic       valid_in;
    logic       en_in;
    logic       flush_in;
    logic [2:0] sel_in;
    logic [7:0] q_a, q_b;
    logic       valid_a, valid_b;
    logic [2:0] count_a, count_b;

    int checks   = 0;
    int failures = 0;

    dff_pipe #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'h00)) dut_a (
        .clk_in    (clk_in),
        .resetn_in (resetn_in),
        .d_in      (d_in),
        .valid_in  (valid_in),
        .en_in     (en_in),
        .flush_in  (flush_in),
        .sel_in    (sel_in),
        .q_out     (q_a),
        .valid_out (valid_a),
        .count_out (count_a)
    );

    dff_pipe #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'h5A)) dut_b (
        .clk_in    (clk_in),
        .resetn_in (resetn_in),
        .d_in      (d_in),
        .valid_in  (valid_in),
        .en_in     (en_in),
        .flush_in  (flush_in),
        .sel_in    (sel_in),
        .q_out     (q_b),
        .valid_out (valid_b),
        .count_out (count_b)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic push(input logic [7:0] d, input logic v);
        d_in     = d;
        valid_in = v;
        en_in    = 1'b1;
        step();
    endtask

    task automatic do_reset();
        resetn_in = 1'b0;
        step();
        resetn_in = 1'b1;
    endtask

    initial begin
        logic [7:0] bub_d   [8];
        logic       bub_v   [8];
        logic [2:0] bub_cnt [8];

        resetn_in = 1'b0;
        d_in      = 8'h00;
        valid_in  = 1'b0;
        en_in     = 1'b0;
        flush_in  = 1'b0;
        sel_in    = 3'd4;
        #1;

        // Reset held for two edges.
        step();
        step();
        check("rst_q",      32'(q_a),     32'h00);
        check("rst_valid",  32'(valid_a), 32'h0);
        check("rst_count",  32'(count_a), 32'h0);
        check("rst_q_5a",   32'(q_b),     32'h5A);
        resetn_in = 1'b1;

        // Stream 11,22,33,44 at sel=4.
        push(8'h11, 1'b1);
        check("stream_cnt1",  32'(count_a), 32'd1);
        check("stream_v_early", 32'(valid_a), 32'h0);
        push(8'h22, 1'b1);
        check("stream_cnt2",  32'(count_a), 32'd2);
        push(8'h33, 1'b1);
        check("stream_cnt3",  32'(count_a), 32'd3);
        push(8'h44, 1'b1);
        check("stream_cnt4",  32'(count_a), 32'd4);
        check("stream_q",     32'(q_a),     32'h11);
        check("stream_valid", 32'(valid_a), 32'h1);

        // Stall at sel=2 after 8'h22 is captured.
        do_reset();
        sel_in = 3'd2;
        push(8'h11, 1'b1);
        push(8'h22, 1'b1);
        en_in    = 1'b0;
        d_in     = 8'hEE;
        valid_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_q",   32'(q_a),     32'h11);
            check("stall_cnt", 32'(count_a), 32'd2);
        end
        push(8'h33, 1'b1);
        check("stall_resume_q", 32'(q_a), 32'h22);

        // Fill with A1..A4, then probe taps combinationally.
        push(8'hA1, 1'b1);
        push(8'hA2, 1'b1);
        push(8'hA3, 1'b1);
        push(8'hA4, 1'b1);
        en_in = 1'b0;
        sel_in = 3'd1; #1; check("tap_sel1", 32'(q_a), 32'hA4);
        sel_in = 3'd3; #1; check("tap_sel3", 32'(q_a), 32'hA2);
        sel_in = 3'd0; #1; check("tap_sel0", 32'(q_a), 32'hA4);
        sel_in = 3'd7; #1; check("tap_sel7", 32'(q_a), 32'hA1);
        check("tap_full_cnt", 32'(count_a), 32'd4);

        // Flush collides with a valid enabled write.
        flush_in = 1'b1;
        push(8'hFF, 1'b1);
        flush_in = 1'b0;
        en_in    = 1'b0;
        check("flush_cnt", 32'(count_a), 32'd0);
        for (int s = 0; s < 8; s++) begin
            sel_in = 3'(s);
            #1;
            check("flush_valid", 32'(valid_a), 32'h0);
        end
        sel_in = 3'd1; #1; check("flush_s1_data", 32'(q_a), 32'hFF);
        sel_in = 3'd2; #1; check("flush_s2_data", 32'(q_a), 32'hA4);

        // Reset mid-stream with en=1, valid=1.
        push(8'h11, 1'b1);
        push(8'h22, 1'b1);
        resetn_in = 1'b0;
        push(8'h77, 1'b1);
        resetn_in = 1'b1;
        en_in     = 1'b0;
        for (int s = 1; s <= 4; s++) begin
            sel_in = 3'(s);
            #1;
            check("midrst_q",     32'(q_a),     32'h00);
            check("midrst_q_5a",  32'(q_b),     32'h5A);
            check("midrst_valid", 32'(valid_a), 32'h0);
        end
        check("midrst_cnt",    32'(count_a), 32'd0);
        check("midrst_cnt_5a", 32'(count_b), 32'd0);

        // Reset pulsed low strictly between edges: no effect.
        push(8'h11, 1'b1);
        push(8'h22, 1'b1);
        en_in = 1'b0;
        resetn_in = 1'b0;
        #3;
        resetn_in = 1'b1;
        sel_in = 3'd1;
        #1;
        check("glitch_cnt_now", 32'(count_a), 32'd2);
        step();
        check("glitch_cnt",   32'(count_a), 32'd2);
        check("glitch_q",     32'(q_a),     32'h22);
        check("glitch_valid", 32'(valid_a), 32'h1);

        // Bubbles 1,0,1,0 then drain; X data on the invalid slots.
        do_reset();
        sel_in  = 3'd4;
        bub_d   = '{8'hB1, 8'hxx, 8'hB3, 8'hxx, 8'hxx, 8'hxx, 8'hxx, 8'hxx};
        bub_v   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        bub_cnt = '{3'd1, 3'd1, 3'd2, 3'd2, 3'd1, 3'd1, 3'd0, 3'd0};
        for (int i = 0; i < 8; i++) begin
            push(bub_d[i], bub_v[i]);
            check("bubble_cnt", 32'(count_a), 32'(bub_cnt[i]));
            if (i >= 3) begin
                check("bubble_valid", 32'(valid_a), 32'(bub_v[i-3]));
            end
            if (i == 3) begin
                check("bubble_q", 32'(q_a), 32'hB1);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dff_pipe.md
Name: dff_pipe

Overview:
- Parametrised successor to the single-bit D flip-flop: a WIDTH-bit, DEPTH-stage register pipeline.
- Adds a clock enable (stall), per-stage valid tracking, a synchronous flush, and a runtime-selectable output tap.
- Registered valid-count output for occupancy monitoring.
- Used as a general delay/alignment line between datapath blocks that need a programmable cycle offset.

Parameters:
- WIDTH, 8, data width in bits (>=1).
- DEPTH, 4, number of pipeline stages (>=1).
- RESET_VAL, {WIDTH{1'b0}}, value loaded into every data stage on reset.
- SEL_W, $clog2(DEPTH+1), width of the tap select and the count output. Derived; not overridden.

Ports:
- clk_in  input  1  single clock; all state changes on its rising edge.
- resetn_in  input  1  reset, synchronous, active-low; sampled only on the clk_in rising edge.
- d_in  input  WIDTH  data into stage 1.
- valid_in  input  1  qualifies d_in.
- en_in  input  1  shift enable; 0 = hold (stall).
- flush_in  input  1  synchronous clear of all valid bits.
- sel_in  input  SEL_W  output tap select, stage 1..DEPTH.
- q_out  output  WIDTH  data of the selected stage.
- valid_out  output  1  valid bit of the selected stage.
- count_out  output  SEL_W  number of stages currently holding valid data (registered).

Behaviour:
- State: data regs s[1..DEPTH], valid bits v[1..DEPTH], count register.
- Priority at each rising edge: reset > flush > enable > hold.
- Reset (resetn_in=0 at edge):
  - all s[k] <= RESET_VAL; all v[k] <= 0; count <= 0.
  - Overrides en_in, flush_in and valid_in in that cycle.
  - Asserting reset mid-stream discards all in-flight data.
  - No asynchronous path: reset low between edges changes nothing.
- Shift (resetn_in=1, en_in=1):
  - s[1] <= d_in; v[1] <= valid_in.
  - s[k] <= s[k-1] and v[k] <= v[k-1] for k=2..DEPTH.
  - Stage DEPTH contents are discarded.
- Hold (en_in=0, flush_in=0): all s, v and count keep their values.
- Flush (resetn_in=1, flush_in=1):
  - all v[k] <= 0 and count <= 0 at that edge.
  - Data regs still follow en_in (shift or hold).
  - valid_in on a flush cycle is dropped: v[1] ends at 0 even if en_in=1 and valid_in=1.
- Output tap:
  - q_out = s[t], valid_out = v[t]. This is a combinational mux of registered state only; there is no path from d_in.
  - t = clamp(sel_in): 0 maps to 1; values >DEPTH map to DEPTH.
  - A change of sel_in takes effect in the same cycle and does not disturb stage contents.
- Latency: a sample captured at an enabled edge appears on q_out after exactly t enabled edges (counting the capture edge). Stalled cycles add no progress.
- count_out:
  - Registered; equals popcount(v[1..DEPTH]) after each edge, updated on the same edge as the v bits. Never exceeds DEPTH.
  - Maintained incrementally or by popcount. Either way it must match v every cycle.
- Reset values of outputs: q_out=RESET_VAL, valid_out=0, count_out=0.
- DEPTH=1: degenerates to one enabled register with valid and flush; sel_in is ignored.
- X on d_in while valid_in=0 must not corrupt the v bits or count_out.

Test Plan (WIDTH=8, DEPTH=4, RESET_VAL=8'h00 unless stated):
- Reset then stream: resetn_in=0 for 2 edges, then en=1, valid=1, d=8'h11,22,33,44, sel=4.
  - After reset: q=00, valid_out=0, count=0.
  - 8'h11 appears on q_out after the 4th enabled edge with valid_out=1; count reads 1,2,3,4.
- Stall: same stream with sel=2, en_in=0 for 3 cycles after 8'h22 is captured.
  - q_out holds 8'h11 and count holds 2 through the stall.
  - 8'h22 appears one enabled edge after en_in returns to 1.
- Tap select and clamp: pipeline full with 8'hA1..A4.
  - sel=1 gives the newest sample; sel=3 gives the third stage same cycle; sel=0 behaves as 1; sel=7 behaves as 4.
- Flush collision: full pipeline, flush_in=1 with en=1, valid_in=1, d=8'hFF.
  - Next cycle: count=0 and valid_out=0 for every sel; s[1] data=8'hFF but v[1]=0.
- Reset mid-stream: after 2 valid samples, drop resetn_in for one edge with en=1 and flush=0.
  - All taps read 8'h00, valid_out=0, count=0.
  - Re-run with RESET_VAL=8'h5A: all taps read 8'h5A.
  - Reset pulsed low between edges only: no state change.
- Bubbles: valid pattern 1,0,1,0 with en=1, sel=4.
  - valid_out follows 1,0,1,0 four enabled edges later.
  - count_out never exceeds 2 while only the pattern is in flight.
